// File: rtl/instr_stream_encoder_pkg.sv
// Shared kind codes, RV32I opcodes and FSM state encoding for the program loader.
package instr_stream_encoder_pkg;

    typedef enum logic [2:0] {
        KIND_LW    = 3'd0,
        KIND_SW    = 3'd1,
        KIND_RTYPE = 3'd2,
        KIND_BEQ   = 3'd3,
        KIND_IALU  = 3'd4,
        KIND_JAL   = 3'd5
    } kind_t;

    // Same opcode values the main decoder matches.
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/instr_stream_encoder_instr_field_packer.sv
// Combinational packer: symbolic instruction fields -> RV32I word plus legality.
// Illegal kinds and out-of-range immediates yield NOP_WORD with legal=0.
module instr_field_packer
    import instr_stream_encoder_pkg::*;
(
    input  logic [2:0]  kind,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        legal
);

    logic signed [31:0] simm;
    logic               imm12_ok;
    logic               br_ok;
    logic               jal_ok;
    logic [31:0]        enc;

    assign simm = imm;

    // Immediate range checks in two's complement.
    always_comb begin
        imm12_ok = (simm >= -32'sd2048) && (simm <= 32'sd2047);
        br_ok    = (simm >= -32'sd4096) && (simm <= 32'sd4094) && !imm[0];
        jal_ok   = (simm >= -32'sd1048576) && (simm <= 32'sd1048574) && !imm[0];
    end

    // Field packing per instruction kind.
    always_comb begin
        enc   = NOP_WORD;
        legal = 1'b0;
        case (kind_t'(kind))
            KIND_LW: begin
                enc   = {imm[11:0], rs1, funct3, rd, OP_LOAD};
                legal = imm12_ok;
            end
            KIND_SW: begin
                enc   = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
                legal = imm12_ok;
            end
            KIND_RTYPE: begin
                enc   = {1'b0, funct7b5, 5'b00000, rs2, rs1, funct3, rd, OP_RTYPE};
                legal = 1'b1;
            end
            KIND_BEQ: begin
                enc   = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
                legal = br_ok;
            end
            KIND_IALU: begin
                enc   = {imm[11:0], rs1, funct3, rd, OP_IALU};
                legal = imm12_ok;
            end
            KIND_JAL: begin
                enc   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
                legal = jal_ok;
            end
            default: begin
                enc   = NOP_WORD;
                legal = 1'b0;
            end
        endcase
        word = legal ? enc : NOP_WORD;
    end

endmodule

// File: rtl/instr_stream_encoder.sv
// Program-loading front end: encodes one symbolic instruction per beat and
// writes it to consecutive instruction-memory words, holding the core in
// reset until the load completes.
module instr_stream_encoder
    import instr_stream_encoder_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7b5,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              err,
    output logic              overflow
);

    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] PTR_MAX = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic              accept;
    logic              load_entry;
    logic [31:0]       pk_word;
    logic              pk_legal;

    instr_field_packer u_packer (
        .kind     (in_kind),
        .funct3   (in_funct3),
        .funct7b5 (in_funct7b5),
        .rd       (in_rd),
        .rs1      (in_rs1),
        .rs2      (in_rs2),
        .imm      (in_imm),
        .word     (pk_word),
        .legal    (pk_legal)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state and handshake/status decode. The move to DONE happens on the
    // accepting edge so no further beat is taken while the final write is out.
    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        done       = 1'b0;
        core_hold  = 1'b1;
        accept     = 1'b0;
        load_entry = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_LOAD;
                    load_entry = 1'b1;
                end
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (accept && (in_last || ptr_q == PTR_MAX))
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                core_hold = 1'b0;
                if (start) begin
                    state_d    = ST_LOAD;
                    load_entry = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Write pointer, registered memory write port and sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q     <= BASE;
            mem_we    <= 1'b0;
            mem_addr  <= BASE;
            mem_wdata <= '0;
            err       <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            mem_we <= accept;
            if (load_entry) begin
                ptr_q    <= BASE;
                err      <= 1'b0;
                overflow <= 1'b0;
            end
            if (accept) begin
                mem_addr  <= ptr_q;
                mem_wdata <= pk_word;
                if (!pk_legal)
                    err <= 1'b1;
                if (ptr_q == PTR_MAX) begin
                    if (!in_last)
                        overflow <= 1'b1;
                end else begin
                    ptr_q <= ptr_q + 1'b1;
                end
            end
        end
    end

endmodule
